// File: rtl/exception_control.sv
// Interrupt/exception entry and exit sequencer for the 5-stage MIPS pipeline.
// Arbitrates the fault sources, flushes, captures EPC/cause and issues one fetch redirect pulse.
module exception_control #(
    parameter int PC_W      = 32,
    parameter int FLUSH_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            intReq,
    input  logic            intEn,
    input  logic            expt1Req,
    input  logic [PC_W-1:0] expt1Pc,
    input  logic            expt2Req,
    input  logic [PC_W-1:0] expt2Pc,
    input  logic [PC_W-1:0] curPc,
    input  logic            rti,
    output logic            intr,
    output logic            expt1,
    output logic            expt2,
    output logic            flush,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause,
    output logic            intPending,
    output logic            inHandler
);

    typedef enum logic [1:0] {IDLE, FLUSH, ISSUE, HANDLER} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_EXPT1 = 2'b01;
    localparam logic [1:0] CAUSE_EXPT2 = 2'b10;
    localparam logic [1:0] CAUSE_INT   = 2'b11;

    state_t          state_reg;
    logic [2:0]      cnt_reg;
    logic            int_prev_reg;

    logic            int_rise;
    logic            can_accept;
    logic            take_int;
    logic            accept;
    logic            int_taken;
    logic [1:0]      win_cause;
    logic [PC_W-1:0] win_pc;

    assign int_rise   = intReq & ~int_prev_reg;
    assign can_accept = (state_reg == IDLE) || (state_reg == HANDLER);
    // Interrupts are masked while a handler runs; exceptions may still nest.
    assign take_int   = intPending & intEn & valid & (state_reg == IDLE);
    assign accept     = can_accept & (expt1Req | expt2Req | take_int);
    assign int_taken  = accept & ~expt1Req & ~expt2Req;

    always_comb begin
        win_cause = CAUSE_INT;
        win_pc    = curPc;
        if (expt1Req) begin
            win_cause = CAUSE_EXPT1;
            win_pc    = expt1Pc;
        end else if (expt2Req) begin
            win_cause = CAUSE_EXPT2;
            win_pc    = expt2Pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            int_prev_reg <= 1'b0;
            intPending   <= 1'b0;
            intr         <= 1'b0;
            expt1        <= 1'b0;
            expt2        <= 1'b0;
            flush        <= 1'b0;
            epc          <= '0;
            cause        <= CAUSE_NONE;
            inHandler    <= 1'b0;
        end else begin
            int_prev_reg <= intReq;
            // A new edge in the acceptance cycle must survive the clear.
            intPending   <= (intPending & ~int_taken) | int_rise;

            case (state_reg)
                IDLE, HANDLER: begin
                    if (accept) begin
                        state_reg <= FLUSH;
                        cnt_reg   <= FLUSH_LOAD;
                        flush     <= 1'b1;
                        epc       <= win_pc;
                        cause     <= win_cause;
                        inHandler <= 1'b0;
                    end else if ((state_reg == HANDLER) && rti && valid) begin
                        state_reg <= IDLE;
                        cause     <= CAUSE_NONE;
                        inHandler <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt_reg == 3'd1) begin
                        state_reg <= ISSUE;
                        flush     <= 1'b0;
                        intr      <= (cause == CAUSE_INT);
                        expt1     <= (cause == CAUSE_EXPT1);
                        expt2     <= (cause == CAUSE_EXPT2);
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ISSUE: begin
                    state_reg <= HANDLER;
                    inHandler <= 1'b1;
                    intr      <= 1'b0;
                    expt1     <= 1'b0;
                    expt2     <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_control.sv
// Self-checking bench for exception_control: scenario tasks plus a redirect-pulse scoreboard.
module tb_exception_control;

    localparam int PC_W = 32;

    logic            clk;
    logic            rst;
    logic            valid;
    logic            intReq;
    logic            intEn;
    logic            expt1Req;
    logic [PC_W-1:0] expt1Pc;
    logic            expt2Req;
    logic [PC_W-1:0] expt2Pc;
    logic [PC_W-1:0] curPc;
    logic            rti;
    logic            intr;
    logic            expt1;
    logic            expt2;
    logic            flush;
    logic [PC_W-1:0] epc;
    logic [1:0]      cause;
    logic            intPending;
    logic            inHandler;

    exception_control #(.PC_W(PC_W), .FLUSH_CYC(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .intReq     (intReq),
        .intEn      (intEn),
        .expt1Req   (expt1Req),
        .expt1Pc    (expt1Pc),
        .expt2Req   (expt2Req),
        .expt2Pc    (expt2Pc),
        .curPc      (curPc),
        .rti        (rti),
        .intr       (intr),
        .expt1      (expt1),
        .expt2      (expt2),
        .flush      (flush),
        .epc        (epc),
        .cause      (cause),
        .intPending (intPending),
        .inHandler  (inHandler)
    );

    typedef struct {
        logic [1:0]      cause;
        logic [PC_W-1:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every redirect pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && (intr || expt1 || expt2)) begin
            exp_t       e;
            logic [2:0] got;
            logic [2:0] req;
            checks++;
            got = {intr, expt1, expt2};
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got int/e1/e2=%b, required none", got);
            end else begin
                e = sb_q.pop_front();
                case (e.cause)
                    2'b11:   req = 3'b100;
                    2'b01:   req = 3'b010;
                    default: req = 3'b001;
                endcase
                if (got !== req || epc !== e.pc || cause !== e.cause || flush !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect got pulse=%b epc=%h cause=%b flush=%b, required pulse=%b epc=%h cause=%b flush=0",
                             got, epc, cause, flush, req, e.pc, e.cause);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one handler entry, reporting the first flush cycle, flush length and pulse arrival.
    task automatic run_entry(output int first, output int nflush, output bit seen);
        first  = 0;
        nflush = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            tick();
            if (i == 1) begin
                expt1Req = 1'b0;
                expt2Req = 1'b0;
                rti      = 1'b0;
            end
            if (flush) begin
                nflush++;
                if (first == 0) first = i;
            end
            if (intr || expt1 || expt2) seen = 1'b1;
        end
    endtask

    task automatic do_rti();
        rti   = 1'b1;
        valid = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid = 1'b0; intReq = 1'b0; intEn = 1'b0; rti = 1'b0;
        expt1Req = 1'b0; expt2Req = 1'b0;
        expt1Pc = '0; expt2Pc = '0; curPc = '0;
        tick();
        tick();
        checks++;
        if ({intr, expt1, expt2, flush, intPending, inHandler} !== 6'b0 || epc !== '0 || cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b epc=%h cause=%b, required all 0",
                     {intr, expt1, expt2, flush, intPending, inHandler}, epc, cause);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (flush !== 1'b0 || intPending !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got flush=%b intPending=%b, required 0 0", flush, intPending);
        end
    endtask

    task automatic test_int();
        int first, nflush;
        bit seen;
        intEn = 1'b1; valid = 1'b1; curPc = 32'h40;
        intReq = 1'b1;
        sb_q.push_back('{cause: 2'b11, pc: 32'h40});
        tick();
        checks++;
        if (intPending !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL int_latch got intPending=%b flush=%b, required 1 0", intPending, flush);
        end
        run_entry(first, nflush, seen);
        checks++;
        if (!seen || first != 1 || nflush != 3) begin
            errors++;
            $display("FAIL int_timing got seen=%0b first=%0d flush=%0d, required 1 1 3", seen, first, nflush);
        end
        checks++;
        if (epc !== 32'h40 || cause !== 2'b11 || intPending !== 1'b0) begin
            errors++;
            $display("FAIL int_capture got epc=%h cause=%b intPending=%b, required 00000040 11 0", epc, cause, intPending);
        end
        tick();
        checks++;
        if (inHandler !== 1'b1 || intr !== 1'b0) begin
            errors++;
            $display("FAIL int_handler got inHandler=%b int=%b, required 1 0", inHandler, intr);
        end
        intReq = 1'b0;
        do_rti();
        checks++;
        if (inHandler !== 1'b0 || cause !== 2'b00 || epc !== 32'h40) begin
            errors++;
            $display("FAIL int_rti got inHandler=%b cause=%b epc=%h, required 0 00 00000040", inHandler, cause, epc);
        end
    endtask

    task automatic test_expt_priority();
        int first, nflush;
        bit seen;
        expt1Pc = 32'h100; expt2Pc = 32'h200;
        expt1Req = 1'b1; expt2Req = 1'b1;
        sb_q.push_back('{cause: 2'b01, pc: 32'h100});
        run_entry(first, nflush, seen);
        checks++;
        if (!seen || first != 1 || nflush != 3) begin
            errors++;
            $display("FAIL prio_timing got seen=%0b first=%0d flush=%0d, required 1 1 3", seen, first, nflush);
        end
        checks++;
        if (epc !== 32'h100 || cause !== 2'b01 || expt2 !== 1'b0) begin
            errors++;
            $display("FAIL prio_capture got epc=%h cause=%b expt2=%b, required 00000100 01 0", epc, cause, expt2);
        end
        tick();
        checks++;
        if (inHandler !== 1'b1) begin
            errors++;
            $display("FAIL prio_handler got inHandler=%b, required 1", inHandler);
        end
        do_rti();
    endtask

    task automatic test_int_masked();
        int first, nflush, busy;
        bit seen;
        intEn = 1'b0; valid = 1'b1; curPc = 32'h80;
        intReq = 1'b1;
        tick();
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (flush || intr || expt1 || expt2) busy++;
        end
        checks++;
        if (busy != 0 || intPending !== 1'b1) begin
            errors++;
            $display("FAIL masked_idle got busy_cycles=%0d intPending=%b, required 0 1", busy, intPending);
        end
        intEn = 1'b1;
        sb_q.push_back('{cause: 2'b11, pc: 32'h80});
        run_entry(first, nflush, seen);
        checks++;
        if (!seen || first != 1 || nflush != 3) begin
            errors++;
            $display("FAIL masked_take got seen=%0b first=%0d flush=%0d, required 1 1 3", seen, first, nflush);
        end
        tick();
        intReq = 1'b0;
    endtask

    task automatic test_int_in_handler();
        int first, nflush, busy;
        bit seen;
        tick();
        intReq = 1'b1;
        tick();
        checks++;
        if (intPending !== 1'b1 || inHandler !== 1'b1) begin
            errors++;
            $display("FAIL handler_latch got intPending=%b inHandler=%b, required 1 1", intPending, inHandler);
        end
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (flush) busy++;
        end
        checks++;
        if (busy != 0 || inHandler !== 1'b1) begin
            errors++;
            $display("FAIL handler_mask got flush_cycles=%0d inHandler=%b, required 0 1", busy, inHandler);
        end
        intReq = 1'b0;
        curPc = 32'hC0; valid = 1'b1; rti = 1'b1;
        sb_q.push_back('{cause: 2'b11, pc: 32'hC0});
        run_entry(first, nflush, seen);
        checks++;
        if (!seen || first != 2 || nflush != 3) begin
            errors++;
            $display("FAIL handler_rti_take got seen=%0b first=%0d flush=%0d, required 1 2 3", seen, first, nflush);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int first, nflush;
        bit seen;
        expt2Pc = 32'h300; expt2Req = 1'b1;
        rti = 1'b1; valid = 1'b1;
        sb_q.push_back('{cause: 2'b10, pc: 32'h300});
        run_entry(first, nflush, seen);
        checks++;
        if (!seen || first != 1 || nflush != 3) begin
            errors++;
            $display("FAIL nested_timing got seen=%0b first=%0d flush=%0d, required 1 1 3", seen, first, nflush);
        end
        checks++;
        if (epc !== 32'h300 || cause !== 2'b10) begin
            errors++;
            $display("FAIL nested_capture got epc=%h cause=%b, required 00000300 10", epc, cause);
        end
        tick();
        do_rti();
        checks++;
        if (inHandler !== 1'b0 || cause !== 2'b00 || epc !== 32'h300) begin
            errors++;
            $display("FAIL nested_rti got inHandler=%b cause=%b epc=%h, required 0 00 00000300", inHandler, cause, epc);
        end
    endtask

    task automatic test_reset_mid_flush();
        int busy;
        expt1Pc = 32'h500; expt1Req = 1'b1;
        tick();
        expt1Req = 1'b0;
        tick();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL midflush_setup got flush=%b, required 1", flush);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({intr, expt1, expt2, flush, intPending, inHandler} !== 6'b0 || epc !== '0 || cause !== 2'b00) begin
            errors++;
            $display("FAIL midflush_reset got flags=%b epc=%h cause=%b, required all 0",
                     {intr, expt1, expt2, flush, intPending, inHandler}, epc, cause);
        end
        tick();
        rst = 1'b1;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (flush || intr || expt1 || expt2) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL midflush_after got busy_cycles=%0d, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_int();
        test_expt_priority();
        test_int_masked();
        test_int_in_handler();
        test_back_to_back();
        test_reset_mid_flush();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_control.md
Name: exception_control

Overview:
- Sequences entry into and exit from interrupt and exception handlers for the 5-stage MIPS pipeline.
- Collects the two exception sources and the external interrupt, and arbitrates them into a single winner.
- Flushes the pipeline, captures the EPC and cause, then emits exactly one single-cycle request (int / expt1 / expt2) to the fetch controller.
- Tracks handler occupancy until return-from-interrupt (rti) commits.

Parameters:
- PC_W, 32, width of PC/EPC values.
- FLUSH_CYC, 3, cycles of flush before the fetch redirect; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  pipeline advancing this cycle (no stall).
- intReq  in  1  external interrupt line; rising edge is latched.
- intEn  in  1  global interrupt enable.
- expt1Req  in  1  invalid-memory-address exception, from the memory stage.
- expt1Pc  in  PC_W  PC of the instruction faulting on expt1.
- expt2Req  in  1  empty-stack exception, from the memory stage.
- expt2Pc  in  PC_W  PC of the instruction faulting on expt2.
- curPc  in  PC_W  PC of the next instruction to commit; used as interrupt return address.
- rti  in  1  rti instruction committing this cycle.
- int  out  1  one-cycle pulse to the fetch controller: interrupt redirect.
- expt1  out  1  one-cycle pulse: expt1 redirect.
- expt2  out  1  one-cycle pulse: expt2 redirect.
- flush  out  1  kill all in-flight instructions.
- epc  out  PC_W  captured return PC.
- cause  out  2  00 none, 01 expt1, 10 expt2, 11 int.
- intPending  out  1  latched interrupt not yet taken.
- inHandler  out  1  handler running; interrupts masked.

Behaviour:
Reset (async, rst=0):
- State IDLE; all outputs 0; epc=0; cause=00; intPending=0; edge-detect register=0.

State machine: IDLE, FLUSH, ISSUE, HANDLER.

Interrupt latch:
- A rising edge of intReq (registered previous value) sets intPending, in any state.
- intPending clears only in the cycle the interrupt is accepted.
- An edge arriving in the same cycle as acceptance keeps intPending set.

Accept condition (IDLE or HANDLER):
- Candidates: expt1Req, expt2Req, and interrupt = intPending & intEn & valid & state==IDLE.
- Priority: expt1 > expt2 > interrupt.
- Losing exceptions are dropped; a losing interrupt stays pending.

On accept:
- epc <= expt1Pc, expt2Pc or curPc, matching the winner.
- cause <= winner code.
- Load the flush counter with FLUSH_CYC; go to FLUSH.

FLUSH:
- flush=1 every cycle; counter decrements.
- On the cycle the counter reaches 1 -> ISSUE.
- expt1Req, expt2Req and rti are ignored here.

ISSUE:
- flush=0; exactly one of int/expt1/expt2 =1 for one cycle, selected by cause.
- Next state HANDLER.

HANDLER:
- inHandler=1; interrupts are not accepted.
- Exceptions are still accepted and overwrite epc/cause (nested fault path).
- rti & valid with no exception in the same cycle -> IDLE; cause <= 00 (epc is held).
- Exception and rti in the same cycle -> the exception wins.

Latency:
- Request sampled at edge N.
- flush high during cycles N+1 .. N+FLUSH_CYC.
- Redirect pulse in cycle N+FLUSH_CYC+1.
- inHandler from cycle N+FLUSH_CYC+2.

Invariants:
- int, expt1 and expt2 are mutually exclusive.
- No pulse is ever emitted outside ISSUE.
- flush and a pulse never coincide.

Reset mid-FLUSH or mid-ISSUE: immediate return to IDLE, and no pulse is emitted.

Test Plan:
- Reset, then intReq 0->1 with intEn=1, valid=1, curPc=0x40 -> intPending=1 next cycle; flush high 3 cycles; int pulse 1 cycle; epc=0x40, cause=11; inHandler=1; intPending=0.
- expt1Req and expt2Req together, expt1Pc=0x100, expt2Pc=0x200 -> epc=0x100, cause=01; single expt1 pulse; expt2 never asserted.
- intPending=1 while intEn=0 for 10 cycles -> no flush and no pulse; raise intEn -> interrupt taken on the next valid cycle.
- In HANDLER, intReq edge -> intPending=1 but no entry; rti with valid -> IDLE, then the interrupt is taken the following cycle.
- In HANDLER, expt2Req and rti in the same cycle, expt2Pc=0x300 -> stays in the handler path; epc=0x300, cause=10; expt2 pulse after flush.
- rst asserted during the second FLUSH cycle -> all outputs 0 immediately; no pulse after rst is released.
